// File: rtl/sd_emmc_dma_axi_arb.sv
// Round-robin arbiter sharing the eMMC M_AXI write port between the block engine (r0) and writeback engine (r1).
// Latency: grant registered 1 cycle after addr_valid; AW/W/ready paths are combinational pass-through while granted.
// Backpressure: m_awready/m_wready flow straight back to the owner; grant locked per burst (and through B when SD_EMMC_DMA_ARB_BRESP_WAIT_EN).
module sd_emmc_dma_axi_arb #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic              r0_addr_valid,
   output logic              r0_addr_ready,
   input  logic [DATA_W-1:0] r0_data,
   input  logic              r0_data_valid,
   output logic              r0_data_ready,
   input  logic              r0_last,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic              r1_addr_valid,
   output logic              r1_addr_ready,
   input  logic [DATA_W-1:0] r1_data,
   input  logic              r1_data_valid,
   output logic              r1_data_ready,
   input  logic              r1_last,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wvalid,
   input  logic              m_wready,
   output logic              m_wlast,
   input  logic              m_bvalid,
   input  logic [1:0]        m_bresp,
   output logic              m_bready,
   output logic [1:0]        grant,
   output logic              arb_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
`ifdef SD_EMMC_DMA_ARB_BRESP_WAIT_EN
   localparam logic [1:0] S_RESP = 2'd3;
`endif

   localparam int             CNT_W   = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
   localparam logic [CNT_W-1:0] CNT_ERR = CNT_W'(MAX_BEATS - 1);

   logic [1:0]       state;
   logic [1:0]       grant_q;
   logic             last_grant;
   logic [CNT_W-1:0] beat_cnt;
   logic             any_req;
   logic             pick_r1;
   logic             aw_fire;
   logic             w_fire;
   logic             burst_err;

   assign any_req = r0_addr_valid | r1_addr_valid;
   // r1 wins when alone, or when both ask and r0 owned the port last
   assign pick_r1 = r1_addr_valid & (~r0_addr_valid | ~last_grant);

   always_comb begin
      m_awaddr      = '0;
      m_awvalid     = 1'b0;
      m_wdata       = '0;
      m_wvalid      = 1'b0;
      m_wlast       = 1'b0;
      r0_addr_ready = 1'b0;
      r1_addr_ready = 1'b0;
      r0_data_ready = 1'b0;
      r1_data_ready = 1'b0;
      if (state == S_ADDR) begin
         if (grant_q[0]) begin
            m_awaddr      = r0_addr;
            m_awvalid     = r0_addr_valid;
            r0_addr_ready = m_awready;
         end else if (grant_q[1]) begin
            m_awaddr      = r1_addr;
            m_awvalid     = r1_addr_valid;
            r1_addr_ready = m_awready;
         end
      end
      if (state == S_DATA) begin
         if (grant_q[0]) begin
            m_wdata       = r0_data;
            m_wvalid      = r0_data_valid;
            m_wlast       = r0_last;
            r0_data_ready = m_wready;
         end else if (grant_q[1]) begin
            m_wdata       = r1_data;
            m_wvalid      = r1_data_valid;
            m_wlast       = r1_last;
            r1_data_ready = m_wready;
         end
      end
   end

   assign aw_fire   = m_awvalid & m_awready;
   assign w_fire    = m_wvalid & m_wready;
   assign burst_err = w_fire & ~m_wlast & (beat_cnt == CNT_ERR);
   assign grant     = grant_q;

`ifdef SD_EMMC_DMA_ARB_BRESP_WAIT_EN
   assign m_bready = (state == S_RESP);
   assign arb_err  = burst_err | ((state == S_RESP) & m_bvalid & (m_bresp != 2'b00));
`else
   logic unused_bresp;
   assign unused_bresp = ^{m_bvalid, m_bresp};
   assign m_bready     = 1'b1;
   assign arb_err      = burst_err;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         grant_q    <= 2'b00;
         last_grant <= 1'b1;
         beat_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  grant_q    <= pick_r1 ? 2'b10 : 2'b01;
                  last_grant <= pick_r1;
                  state      <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (aw_fire) begin
                  state    <= S_DATA;
                  beat_cnt <= '0;
               end
            end
            S_DATA: begin
               if (w_fire) begin
                  if (beat_cnt != CNT_MAX) beat_cnt <= beat_cnt + CNT_W'(1);
                  if (m_wlast) begin
`ifdef SD_EMMC_DMA_ARB_BRESP_WAIT_EN
                     state <= S_RESP;
`else
                     state   <= S_IDLE;
                     grant_q <= 2'b00;
`endif
                  end
               end
            end
`ifdef SD_EMMC_DMA_ARB_BRESP_WAIT_EN
            S_RESP: begin
               if (m_bvalid) begin
                  state   <= S_IDLE;
                  grant_q <= 2'b00;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_emmc_dma_axi_arb.sv
// Bench for sd_emmc_dma_axi_arb: requester drivers push expected AW/W traffic, an AXI-side monitor pops and compares.
module tb_sd_emmc_dma_axi_arb;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] r0_addr = '0, r1_addr = '0, r0_data = '0, r1_data = '0;
   logic        r0_addr_valid = 1'b0, r1_addr_valid = 1'b0;
   logic        r0_data_valid = 1'b0, r1_data_valid = 1'b0;
   logic        r0_last = 1'b0, r1_last = 1'b0;
   logic        r0_addr_ready, r1_addr_ready, r0_data_ready, r1_data_ready;
   logic [31:0] m_awaddr, m_wdata;
   logic        m_awvalid, m_wvalid, m_wlast, m_bready, arb_err;
   logic        m_awready = 1'b1, m_wready = 1'b1, m_bvalid = 1'b0;
   logic [1:0]  m_bresp = 2'b00;
   logic [1:0]  grant;

   sd_emmc_dma_axi_arb dut (
      .clock(clock), .reset(reset),
      .r0_addr(r0_addr), .r0_addr_valid(r0_addr_valid), .r0_addr_ready(r0_addr_ready),
      .r0_data(r0_data), .r0_data_valid(r0_data_valid), .r0_data_ready(r0_data_ready), .r0_last(r0_last),
      .r1_addr(r1_addr), .r1_addr_valid(r1_addr_valid), .r1_addr_ready(r1_addr_ready),
      .r1_data(r1_data), .r1_data_valid(r1_data_valid), .r1_data_ready(r1_data_ready), .r1_last(r1_last),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
      .grant(grant), .arb_err(arb_err)
   );

   always #5 clock = ~clock;

   int          checks = 0, errors = 0;
   logic [31:0] exp_a0[$], exp_a1[$];
   logic [32:0] exp_d0[$], exp_d1[$];
   logic [1:0]  gseq[$];
   int          beats_seen = 0, err_cnt = 0, err_beat = -1;
   bit          abort = 1'b0;
   logic [1:0]  resp_code = 2'b00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // AXI-side monitor / scoreboard consumer
   always @(negedge clock) begin
      if (!reset) begin
         if (grant == 2'b11) chk("grant_onehot", grant, 2'b01);
         if (arb_err) begin
            err_cnt++;
            err_beat = beats_seen;
         end
         if (m_awvalid && m_awready) begin
            gseq.push_back(grant);
            if (grant == 2'b01 && exp_a0.size() > 0)      chk("awaddr_r0", m_awaddr, exp_a0.pop_front());
            else if (grant == 2'b10 && exp_a1.size() > 0) chk("awaddr_r1", m_awaddr, exp_a1.pop_front());
            else                                          chk("aw_unexpected", 1, 0);
         end
         if (m_wvalid && m_wready) begin
            if (grant == 2'b01 && exp_d0.size() > 0)      chk("wbeat_r0", {m_wlast, m_wdata}, exp_d0.pop_front());
            else if (grant == 2'b10 && exp_d1.size() > 0) chk("wbeat_r1", {m_wlast, m_wdata}, exp_d1.pop_front());
            else                                          chk("w_unexpected", 1, 0);
            beats_seen++;
         end
      end
   end

   // Write-response generator: answers two cycles after each last beat
   initial begin
      int n;
      forever begin
         @(negedge clock);
         if (!reset && m_wvalid && m_wready && m_wlast) begin
            repeat (2) @(posedge clock);
            #1 m_bvalid = 1'b1; m_bresp = resp_code;
            n = 0;
            @(negedge clock);
            while (!m_bready && n < 20) begin @(negedge clock); n++; end
            @(posedge clock);
            #1 m_bvalid = 1'b0; m_bresp = 2'b00;
         end
      end
   end

   function automatic logic addr_rdy(input int rq);
      return (rq == 0) ? r0_addr_ready : r1_addr_ready;
   endfunction

   function automatic logic data_rdy(input int rq);
      return (rq == 0) ? r0_data_ready : r1_data_ready;
   endfunction

   task automatic send(input int rq, input logic [31:0] addr, input int nb, input bit lastflag);
      int n;
      logic [31:0] d;
      logic lst;
      @(posedge clock); #1;
      if (abort) return;
      if (rq == 0) begin r0_addr = addr; r0_addr_valid = 1'b1; exp_a0.push_back(addr); end
      else         begin r1_addr = addr; r1_addr_valid = 1'b1; exp_a1.push_back(addr); end
      n = 0;
      @(negedge clock);
      while (!addr_rdy(rq) && !abort && n < 200) begin @(negedge clock); n++; end
      if (abort) return;
      chk("addr_wait_bound", n < 200, 1);
      @(posedge clock); #1;
      if (rq == 0) r0_addr_valid = 1'b0; else r1_addr_valid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         d   = $urandom;
         lst = lastflag && (i == nb - 1);
         if (rq == 0) begin r0_data = d; r0_data_valid = 1'b1; r0_last = lst; exp_d0.push_back({lst, d}); end
         else         begin r1_data = d; r1_data_valid = 1'b1; r1_last = lst; exp_d1.push_back({lst, d}); end
         n = 0;
         @(negedge clock);
         while (!data_rdy(rq) && !abort && n < 200) begin @(negedge clock); n++; end
         if (abort) return;
         chk("data_wait_bound", n < 200, 1);
         @(posedge clock); #1;
      end
      if (rq == 0) begin r0_data_valid = 1'b0; r0_last = 1'b0; end
      else         begin r1_data_valid = 1'b0; r1_last = 1'b0; end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clock);
      while (grant != 2'b00 && n < 60) begin @(negedge clock); n++; end
      chk(name, n < 60, 1);
   endtask

   task automatic chk_queues_empty(input string name);
      chk(name, exp_a0.size() + exp_a1.size() + exp_d0.size() + exp_d1.size(), 0);
   endtask

   typedef struct {
      bit         r0;
      bit         r1;
      int         nb;
      int         ng;
      logic [1:0] g0;
      logic [1:0] g1;
   } vec_t;

   vec_t tbl[7];

   initial begin #500000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

   initial begin
      int bs, eb;
      logic [31:0] held;

      // last_grant=0 after the opening r0-only burst, then follows each winner
      tbl[0] = '{1, 1, 2, 2, 2'b10, 2'b01};
      tbl[1] = '{0, 1, 1, 1, 2'b10, 2'b00};
      tbl[2] = '{1, 1, 3, 2, 2'b01, 2'b10};
      tbl[3] = '{1, 0, 4, 1, 2'b01, 2'b00};
      tbl[4] = '{1, 1, 1, 2, 2'b10, 2'b01};
      tbl[5] = '{0, 1, 2, 1, 2'b10, 2'b00};
      tbl[6] = '{1, 1, 2, 2, 2'b01, 2'b10};

      #1;
      chk("rst_grant", grant, 2'b00);
      chk("rst_awvalid", m_awvalid, 0);
      chk("rst_wvalid", m_wvalid, 0);
      chk("rst_wlast", m_wlast, 0);
      chk("rst_readies", {r0_addr_ready, r1_addr_ready, r0_data_ready, r1_data_ready}, 4'b0000);
      chk("rst_arb_err", arb_err, 0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Single r0 burst: AW one cycle after request, four beats
      bs = beats_seen;
      fork
         send(0, 32'h1000_0000, 4, 1);
         begin
            @(posedge clock);
            @(negedge clock);
            chk("lat_awvalid_c0", m_awvalid, 0);
            @(negedge clock);
            chk("lat_awvalid_c1", m_awvalid, 1);
            chk("lat_grant", grant, 2'b01);
            chk("lat_r1_addr_ready", r1_addr_ready, 0);
         end
      join
      wait_idle("single_idle");
      chk("single_beats", beats_seen - bs, 4);
      chk_queues_empty("single_queues");

      for (int i = 0; i < 7; i++) begin
         gseq.delete();
         fork
            begin if (tbl[i].r0) send(0, 32'h2000_0000 + 32'(i) * 32'h100, tbl[i].nb, 1); end
            begin if (tbl[i].r1) send(1, 32'h3000_0000 + 32'(i) * 32'h100, tbl[i].nb, 1); end
         join
         wait_idle($sformatf("v%0d_idle", i));
         chk($sformatf("v%0d_ngrants", i), gseq.size(), tbl[i].ng);
         if (gseq.size() > 0) chk($sformatf("v%0d_first", i), gseq[0], tbl[i].g0);
         if (gseq.size() > 1) chk($sformatf("v%0d_second", i), gseq[1], tbl[i].g1);
         chk_queues_empty($sformatf("v%0d_queues", i));
      end
      chk("no_spurious_err", err_cnt, 0);

      // Fairness: r0 re-requests during its final beat while r1 waits
      gseq.delete();
      fork
         begin send(0, 32'h6000_0000, 2, 1); send(0, 32'h6000_0100, 1, 1); end
         send(1, 32'h6100_0000, 2, 1);
         begin
            int n = 0;
            @(negedge clock);
            while (!(grant == 2'b01 && m_wvalid && m_wready && m_wlast) && n < 100) begin @(negedge clock); n++; end
            r0_addr = 32'h6000_0100; r0_addr_valid = 1'b1;
         end
      join
      wait_idle("fair_idle");
      chk("fair_ngrants", gseq.size(), 3);
      if (gseq.size() == 3) chk("fair_order", {gseq[0], gseq[1], gseq[2]}, 6'b01_10_01);
      chk_queues_empty("fair_queues");

      // Backpressure: wready low for three cycles after beat 2
      bs = beats_seen;
      fork
         send(0, 32'h4000_0000, 6, 1);
         begin
            int n = 0;
            while (beats_seen - bs < 2 && n < 100) begin @(posedge clock); n++; end
            #1 m_wready = 1'b0;
            held = '0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clock);
               if (k == 0) held = m_wdata;
               chk("stall_wvalid", m_wvalid, 1);
               chk("stall_wdata", m_wdata, held);
               chk("stall_r0_ready", r0_data_ready, 0);
            end
            @(posedge clock);
            #1 m_wready = 1'b1;
         end
      join
      wait_idle("stall_idle");
      chk("stall_beats", beats_seen - bs, 6);
      chk_queues_empty("stall_queues");

      // Overlong burst: 17 beats, last only on the 17th
      bs = beats_seen; eb = err_cnt;
      send(0, 32'h7000_0000, 17, 1);
      wait_idle("long_idle");
      chk("long_err_pulses", err_cnt - eb, 1);
      chk("long_err_beat", err_beat - bs, 15);
      chk("long_beats", beats_seen - bs, 17);
      chk_queues_empty("long_queues");

`ifdef SD_EMMC_DMA_ARB_BRESP_WAIT_EN
      resp_code = 2'b10; eb = err_cnt;
      send(1, 32'h5000_0000, 2, 1);
      @(negedge clock);
      chk("resp_grant_held", grant, 2'b10);
      chk("resp_bready", m_bready, 1);
      chk("resp_no_err_yet", arb_err, 0);
      @(negedge clock);
      chk("resp_bvalid", m_bvalid, 1);
      chk("resp_err_pulse", arb_err, 1);
      chk("resp_grant_held2", grant, 2'b10);
      @(negedge clock);
      chk("resp_idle", grant, 2'b00);
      chk("resp_err_count", err_cnt - eb, 1);
      resp_code = 2'b00;
`else
      send(1, 32'h5000_0000, 2, 1);
      @(negedge clock);
      chk("nresp_grant_released", grant, 2'b00);
      chk("nresp_bready", m_bready, 1);
`endif
      chk_queues_empty("resp_queues");

      // Asynchronous reset in the middle of a data burst
      bs = beats_seen;
      fork
         send(0, 32'h8000_0000, 8, 1);
         begin
            int n = 0;
            while (beats_seen - bs < 3 && n < 100) begin @(posedge clock); n++; end
            @(negedge clock);
            #2 reset = 1'b1;
            #1;
            chk("arst_grant", grant, 2'b00);
            chk("arst_wvalid", m_wvalid, 0);
            chk("arst_wlast", m_wlast, 0);
            chk("arst_wdata", m_wdata, 0);
            chk("arst_r0_data_ready", r0_data_ready, 0);
            chk("arst_awvalid", m_awvalid, 0);
            chk("arst_err", arb_err, 0);
            abort = 1'b1;
         end
      join
      r0_addr_valid = 1'b0; r0_data_valid = 1'b0; r0_last = 1'b0;
      exp_a0.delete(); exp_a1.delete(); exp_d0.delete(); exp_d1.delete();
      abort = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
      gseq.delete();
      fork
         send(0, 32'h9000_0000, 2, 1);
         send(1, 32'h9100_0000, 2, 1);
      join
      wait_idle("post_rst_idle");
      chk("post_rst_ngrants", gseq.size(), 2);
      if (gseq.size() == 2) chk("post_rst_order", {gseq[0], gseq[1]}, 4'b01_10);
      chk_queues_empty("post_rst_queues");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
